// File: rtl/util_axis_rr_arbiter_pkg.sv
// Shared util package: arbiter FSM encoding and a clog2 width helper for the converter cores.
// Pure types/functions, no logic.
// No flow control of its own.
package util_axis_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Never returns less than 1 so single-entry indices stay legal vectors.
    function automatic int util_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/util_rr_select.sv
// Round-robin priority selector: first set request searching upward from last_grant+1, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when to sample the result.
module util_rr_select #(
    parameter int slave_count = 4,
    parameter int idx_w       = 2
) (
    input  logic [slave_count-1:0] req_vld,
    input  logic [idx_w-1:0]       last_grant,
    output logic [idx_w-1:0]       grant_idx,
    output logic                   any_vld
);

    always_comb begin
        int cand;
        cand      = 0;
        grant_idx = '0;
        any_vld   = |req_vld;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int off = slave_count; off >= 1; off--) begin
            cand = (int'(last_grant) + off) % slave_count;
            if (req_vld[idx_w'(cand)]) begin
                grant_idx = idx_w'(cand);
            end
        end
    end

endmodule

// File: rtl/util_axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter merging slave_count requesters onto one shared converter port.
// Latency: one arbitration cycle per grant, then one cycle from accepted beat to m_axis output.
// Backpressure: grantee ready follows the output register (~m_axis_tvalid | m_axis_tready); others held off.
module util_axis_rr_arbiter
    import util_axis_rr_arbiter_pkg::*;
#(
    parameter int slave_count  = 4,
    parameter int bus_width    = 16,
    parameter int burst_length = 8
) (
    input  logic                                aclk,
    input  logic                                arstn,
    input  logic [slave_count*bus_width*8-1:0]  s_axis_tdata,
    input  logic [slave_count-1:0]              s_axis_tvalid,
    output logic [slave_count-1:0]              s_axis_tready,
    output logic [bus_width*8-1:0]              m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [util_clog2(slave_count)-1:0]  m_axis_tdest
);

    localparam int idx_w  = util_clog2(slave_count);
    localparam int data_w = bus_width * 8;
    localparam int cnt_w  = util_clog2(burst_length + 1);

    localparam logic [cnt_w-1:0] last_beat  = cnt_w'(burst_length - 1);
    localparam logic [idx_w-1:0] last_slave = idx_w'(slave_count - 1);

    arb_state_t        state_q, state_d;
    logic [idx_w-1:0]  grant_q, last_grant_q, sel_idx;
    logic [cnt_w-1:0]  beat_cnt_q;
    logic [data_w-1:0] grant_dat;
    logic              sel_vld, arb_en_q;
    logic              out_rdy, grant_vld, beat_acc, burst_end, idle_release;

    util_rr_select #(
        .slave_count (slave_count),
        .idx_w       (idx_w)
    ) u_rr_select (
        .req_vld    (s_axis_tvalid),
        .last_grant (last_grant_q),
        .grant_idx  (sel_idx),
        .any_vld    (sel_vld)
    );

    assign out_rdy      = ~m_axis_tvalid | m_axis_tready;
    assign grant_vld    = s_axis_tvalid[grant_q];
    assign beat_acc     = (state_q == ST_GRANT) && grant_vld && out_rdy;
    assign burst_end    = beat_acc && (beat_cnt_q == last_beat);
    assign idle_release = (state_q == ST_GRANT) && out_rdy && !grant_vld;

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < slave_count; i++) begin
            if (grant_q == idx_w'(i)) begin
                grant_dat = s_axis_tdata[i*data_w +: data_w];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_en_q && sel_vld) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_axis_tready[grant_q] = out_rdy;
                // Burst limit and idle release share the same target state.
                if (burst_end || idle_release) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q       <= ST_IDLE;
            arb_en_q      <= 1'b0;
            grant_q       <= '0;
            last_grant_q  <= last_slave;
            beat_cnt_q    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tdest  <= '0;
        end else begin
            state_q  <= state_d;
            // Blocks arbitration on the first edge after reset release.
            arb_en_q <= 1'b1;
            if (state_q == ST_IDLE && state_d == ST_GRANT) begin
                grant_q      <= sel_idx;
                last_grant_q <= sel_idx;
                beat_cnt_q   <= '0;
            end else if (beat_acc) begin
                beat_cnt_q <= beat_cnt_q + cnt_w'(1);
            end
            if (beat_acc) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= grant_dat;
                m_axis_tdest  <= grant_q;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
